// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Fixed-priority (core first) arbiter sharing the mapped-register
//            bus between the core load/store port and the debug access port.
//            Define MEM_ARB_STARVE_GUARD_EN to enable the debug starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_coreReq,
    input  logic [13:0] i_coreAddr,
    input  logic [15:0] i_coreData,
    input  logic        i_coreWrEn,
    output logic        o_coreGnt,
    output logic        o_coreRdValid,
    output logic [15:0] o_coreRdData,
    input  logic        i_dbgReq,
    input  logic [13:0] i_dbgAddr,
    input  logic [15:0] i_dbgData,
    input  logic        i_dbgWrEn,
    output logic        o_dbgGnt,
    output logic        o_dbgRdValid,
    output logic [15:0] o_dbgRdData,
    output logic [13:0] o_memAddr,
    output logic [15:0] o_memDataOut,
    output logic        o_memWrEn,
    input  logic [15:0] i_memDataIn
);

    localparam logic c_OWNER_CORE = 1'b0;
    localparam logic c_OWNER_DBG  = 1'b1;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_badStarveLimit
        $error("mem_bus_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic        w_forceDbg;
    logic        w_accept;

    logic        r_s1Valid;
    logic        r_s1Owner;
    logic [13:0] r_s1Addr;
    logic [15:0] r_s1Data;
    logic        r_s1Wr;

    logic        r_coreRdValid;
    logic [15:0] r_coreRdData;
    logic        r_dbgRdValid;
    logic [15:0] r_dbgRdData;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starveCnt;

    // Counts consecutive denied debug cycles; any grant or idle cycle restarts it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_starveCnt <= 4'd0;
        end else if (i_dbgReq && !o_dbgGnt) begin
            if (r_starveCnt < c_STARVE_LIMIT) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end
        end else begin
            r_starveCnt <= 4'd0;
        end
    end

    assign w_forceDbg = (r_starveCnt >= c_STARVE_LIMIT);
`else
    assign w_forceDbg = 1'b0;
`endif

    // Grants are masked during reset so every output reads 0 while i_rstn is low.
    assign o_coreGnt = i_rstn & i_coreReq & ~w_forceDbg;
    assign o_dbgGnt  = i_rstn & i_dbgReq & (~i_coreReq | w_forceDbg);
    assign w_accept  = o_coreGnt | o_dbgGnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_s1Valid <= 1'b0;
            r_s1Owner <= c_OWNER_CORE;
            r_s1Addr  <= 14'd0;
            r_s1Data  <= 16'd0;
            r_s1Wr    <= 1'b0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1Owner <= o_dbgGnt ? c_OWNER_DBG : c_OWNER_CORE;
            r_s1Addr  <= o_dbgGnt ? i_dbgAddr  : i_coreAddr;
            r_s1Data  <= o_dbgGnt ? i_dbgData  : i_coreData;
            r_s1Wr    <= o_dbgGnt ? i_dbgWrEn  : i_coreWrEn;
        end else begin
            r_s1Valid <= 1'b0;
        end
    end

    assign o_memAddr    = r_s1Valid ? r_s1Addr : 14'd0;
    assign o_memDataOut = r_s1Valid ? r_s1Data : 16'd0;
    assign o_memWrEn    = r_s1Valid & r_s1Wr;

    // Read data is captured while the bus is driven and presented the next cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_coreRdValid <= 1'b0;
            r_coreRdData  <= 16'd0;
            r_dbgRdValid  <= 1'b0;
            r_dbgRdData   <= 16'd0;
        end else begin
            r_coreRdValid <= 1'b0;
            r_dbgRdValid  <= 1'b0;
            if (r_s1Valid && !r_s1Wr) begin
                if (r_s1Owner == c_OWNER_DBG) begin
                    r_dbgRdValid <= 1'b1;
                    r_dbgRdData  <= i_memDataIn;
                end else begin
                    r_coreRdValid <= 1'b1;
                    r_coreRdData  <= i_memDataIn;
                end
            end
        end
    end

    assign o_coreRdValid = r_coreRdValid;
    assign o_coreRdData  = r_coreRdData;
    assign o_dbgRdValid  = r_dbgRdValid;
    assign o_dbgRdData   = r_dbgRdData;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter (transaction-level model
//            plus directed scenarios). Honours MEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int c_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        coreReq = 1'b0, coreWrEn = 1'b0, dbgReq = 1'b0, dbgWrEn = 1'b0;
    logic [13:0] coreAddr = '0, dbgAddr = '0;
    logic [15:0] coreData = '0, dbgData = '0;
    logic        coreGnt, coreRdValid, dbgGnt, dbgRdValid, memWrEn;
    logic [15:0] coreRdData, dbgRdData, memDataOut, memDataIn;
    logic [13:0] memAddr;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    mem_bus_arbiter #(.STARVE_LIMIT(c_LIMIT)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_coreReq(coreReq), .i_coreAddr(coreAddr), .i_coreData(coreData), .i_coreWrEn(coreWrEn),
        .o_coreGnt(coreGnt), .o_coreRdValid(coreRdValid), .o_coreRdData(coreRdData),
        .i_dbgReq(dbgReq), .i_dbgAddr(dbgAddr), .i_dbgData(dbgData), .i_dbgWrEn(dbgWrEn),
        .o_dbgGnt(dbgGnt), .o_dbgRdValid(dbgRdValid), .o_dbgRdData(dbgRdData),
        .o_memAddr(memAddr), .o_memDataOut(memDataOut), .o_memWrEn(memWrEn),
        .i_memDataIn(memDataIn)
    );

    always #5 clk = ~clk;

    // Mapped-register bus slave seen by the DUT, and the model's own copy.
    logic [15:0] busMem   [0:16383];
    logic [15:0] modelMem [0:16383];
    assign memDataIn = busMem[memAddr];
    always @(posedge clk) if (memWrEn) busMem[memAddr] <= memDataOut;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- Transaction-level model ----------------
    typedef struct {
        bit          valid;
        bit          isDbg;
        logic [13:0] addr;
        logic [15:0] data;
        bit          wr;
    } xfer_t;

    xfer_t       mPend;
    int          mCnt;
    bit          mRdValid [2];
    logic [15:0] mRdData  [2];

    function automatic bit expForce();
`ifdef MEM_ARB_STARVE_GUARD_EN
        return mCnt >= c_LIMIT;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit expCoreGnt();
        return rstn && coreReq && !expForce();
    endfunction

    function automatic bit expDbgGnt();
        return rstn && dbgReq && (!coreReq || expForce());
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mPend = '{default: '0};
            mCnt = 0;
            mRdValid = '{0, 0};
            mRdData = '{16'h0, 16'h0};
        end else begin
            bit cg, dg;
            cg = expCoreGnt();
            dg = expDbgGnt();
            mRdValid = '{0, 0};
            if (mPend.valid && mPend.wr) modelMem[mPend.addr] = mPend.data;
            if (mPend.valid && !mPend.wr) begin
                mRdValid[int'(mPend.isDbg)] = 1'b1;
                mRdData[int'(mPend.isDbg)]  = modelMem[mPend.addr];
            end
            if (cg)      mPend = '{1'b1, 1'b0, coreAddr, coreData, coreWrEn};
            else if (dg) mPend = '{1'b1, 1'b1, dbgAddr, dbgData, dbgWrEn};
            else         mPend = '{default: '0};
            if (dbgReq && !dg) mCnt = (mCnt + 1 > c_LIMIT) ? c_LIMIT : mCnt + 1;
            else               mCnt = 0;
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            chk("cmp_coreGnt",     {15'd0, coreGnt},     {15'd0, expCoreGnt()});
            chk("cmp_dbgGnt",      {15'd0, dbgGnt},      {15'd0, expDbgGnt()});
            chk("cmp_memAddr",     {2'd0, memAddr},      mPend.valid ? {2'd0, mPend.addr} : 16'd0);
            chk("cmp_memDataOut",  memDataOut,           mPend.valid ? mPend.data : 16'd0);
            chk("cmp_memWrEn",     {15'd0, memWrEn},     {15'd0, mPend.valid && mPend.wr});
            chk("cmp_coreRdValid", {15'd0, coreRdValid}, {15'd0, mRdValid[0]});
            chk("cmp_coreRdData",  coreRdData,           mRdData[0]);
            chk("cmp_dbgRdValid",  {15'd0, dbgRdValid},  {15'd0, mRdValid[1]});
            chk("cmp_dbgRdData",   dbgRdData,            mRdData[1]);
        end
    end

    // ---------------- Directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic allZero(input string tag);
        chk({tag, "_coreGnt"},  {15'd0, coreGnt}, 16'd0);
        chk({tag, "_dbgGnt"},   {15'd0, dbgGnt}, 16'd0);
        chk({tag, "_memWrEn"},  {15'd0, memWrEn}, 16'd0);
        chk({tag, "_memAddr"},  {2'd0, memAddr}, 16'd0);
        chk({tag, "_memData"},  memDataOut, 16'd0);
        chk({tag, "_coreRdV"},  {15'd0, coreRdValid}, 16'd0);
        chk({tag, "_dbgRdV"},   {15'd0, dbgRdValid}, 16'd0);
        chk({tag, "_coreRdD"},  coreRdData, 16'd0);
        chk({tag, "_dbgRdD"},   dbgRdData, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            busMem[i]   = 16'(i * 3 + 16'h0100);
            modelMem[i] = 16'(i * 3 + 16'h0100);
        end
        busMem[14'h0014]   = 16'h1234;
        modelMem[14'h0014] = 16'h1234;

        repeat (2) @(negedge clk);
        cmpEn = 1'b1;
        allZero("reset");
        rstn = 1'b1;

        // 1: core write
        step();
        coreReq = 1; coreAddr = 14'h0009; coreData = 16'hA5A5; coreWrEn = 1;
        @(negedge clk); chk("t1_coreGnt", {15'd0, coreGnt}, 16'd1);
        step(); coreReq = 0;
        @(negedge clk);
        chk("t1_memWrEn", {15'd0, memWrEn}, 16'd1);
        chk("t1_memAddr", {2'd0, memAddr}, 16'h0009);
        chk("t1_memData", memDataOut, 16'hA5A5);
        step();
        @(negedge clk);
        chk("t1_memWrEn_off", {15'd0, memWrEn}, 16'd0);
        chk("t1_noRdValid", {15'd0, coreRdValid}, 16'd0);

        // 2: debug read
        step();
        dbgReq = 1; dbgAddr = 14'h0014; dbgWrEn = 0;
        @(negedge clk); chk("t2_dbgGnt", {15'd0, dbgGnt}, 16'd1);
        step(); dbgReq = 0;
        @(negedge clk);
        chk("t2_memAddr", {2'd0, memAddr}, 16'h0014);
        chk("t2_rdValid_early", {15'd0, dbgRdValid}, 16'd0);
        step();
        @(negedge clk);
        chk("t2_rdValid", {15'd0, dbgRdValid}, 16'd1);
        chk("t2_rdData", dbgRdData, 16'h1234);
        step();
        @(negedge clk);
        chk("t2_rdValid_off", {15'd0, dbgRdValid}, 16'd0);
        chk("t2_rdData_hold", dbgRdData, 16'h1234);

        // 3: simultaneous, core drops after its grant
        step();
        coreReq = 1; coreAddr = 14'h0100; coreWrEn = 0;
        dbgReq  = 1; dbgAddr  = 14'h0200; dbgWrEn  = 0;
        @(negedge clk);
        chk("t3_coreGnt", {15'd0, coreGnt}, 16'd1);
        chk("t3_dbgWait", {15'd0, dbgGnt}, 16'd0);
        step(); coreReq = 0;
        @(negedge clk);
        chk("t3_dbgGnt", {15'd0, dbgGnt}, 16'd1);
        chk("t3_busCore", {2'd0, memAddr}, 16'h0100);
        step(); dbgReq = 0;
        @(negedge clk);
        chk("t3_busDbg", {2'd0, memAddr}, 16'h0200);
        chk("t3_coreRd", coreRdData, 16'h0400);
        step();
        @(negedge clk);
        chk("t3_dbgRd", dbgRdData, 16'h0700);

`ifdef MEM_ARB_STARVE_GUARD_EN
        // 4: starvation guard, period 5
        step();
        coreReq = 1; coreAddr = 14'h0020; dbgReq = 1; dbgAddr = 14'h0030;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("t4_dbgGnt", {15'd0, dbgGnt}, (i % 5 == 4) ? 16'd1 : 16'd0);
            chk("t4_coreGnt", {15'd0, coreGnt}, (i % 5 == 4) ? 16'd0 : 16'd1);
            step();
        end
        coreReq = 0; dbgReq = 0;
`else
        // 5: strict priority starves debug
        step();
        coreReq = 1; coreAddr = 14'h0020; dbgReq = 1; dbgAddr = 14'h0030;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("t5_dbgStarved", {15'd0, dbgGnt}, 16'd0);
            step();
        end
        coreReq = 0;
        @(negedge clk);
        chk("t5_dbgGnt", {15'd0, dbgGnt}, 16'd1);
        step(); dbgReq = 0;
`endif
        step();

        // 6: reset mid-transfer
        coreReq = 1; coreAddr = 14'h0033; coreData = 16'hBEEF; coreWrEn = 1;
        @(negedge clk); chk("t6_coreGnt", {15'd0, coreGnt}, 16'd1);
        step(); coreReq = 0;
        #1;
        chk("t6_memWrEn_pre", {15'd0, memWrEn}, 16'd1);
        rstn = 1'b0;
        #1;
        allZero("t6_rst");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("t6_noCommit", busMem[14'h0033], 16'(16'h0033 * 3 + 16'h0100));
        dbgReq = 1; dbgAddr = 14'h0014; dbgWrEn = 0;
        @(negedge clk); chk("t6_dbgGnt", {15'd0, dbgGnt}, 16'd1);
        step(); dbgReq = 0;
        step();
        @(negedge clk);
        chk("t6_rdValid", {15'd0, dbgRdValid}, 16'd1);
        chk("t6_rdData", dbgRdData, 16'h1234);
        step();
        @(negedge clk);

        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Two-requester arbiter that shares the mapped-register memory bus between the core load/store port and the debug access port.
- Sits between both requesters and the mapped-register bus (14-bit address, 16-bit data, combinational read data).
- Fixed priority: the core wins.
- Optional starvation guard forces a debug grant after a bounded wait.
- Transfers are pipelined: one accept per cycle, bus access one cycle after accept, read response one cycle after that.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied debug-request cycles before a debug grant is forced. Legal range is 1..15.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_coreReq  in  1  core request valid.
- i_coreAddr  in  14  core address.
- i_coreData  in  16  core write data.
- i_coreWrEn  in  1  1 = write, 0 = read.
- o_coreGnt  out  1  core request accepted this cycle (combinational).
- o_coreRdValid  out  1  core read data valid (one-cycle pulse).
- o_coreRdData  out  16  core read data.
- i_dbgReq, i_dbgAddr[13:0], i_dbgData[15:0], i_dbgWrEn  in  debug request; same meanings as the core request signals.
- o_dbgGnt, o_dbgRdValid, o_dbgRdData[15:0]  out  debug responses; same meanings as the core responses.
- o_memAddr  out  14  bus address.
- o_memDataOut  out  16  bus write data.
- o_memWrEn  out  1  bus write strobe.
- i_memDataIn  in  16  bus read data (combinational from mapped registers).

## Operation
Grant logic (combinational):
- forceDbg = (starveCnt >= STARVE_LIMIT).
- o_coreGnt = i_coreReq & ~forceDbg.
- o_dbgGnt = i_dbgReq & (~i_coreReq | forceDbg).
- At most one grant is high in any cycle.

Handshake:
- A transfer is accepted at the rising edge where req & gnt.
- A requester holds req, addr, data and wrEn stable until it sees gnt.
- It may present a new request in the very next cycle.

Stage 1 registers (s1Valid, s1Owner, s1Addr, s1Data, s1Wr):
- Loaded on accept.
- s1Valid clears on any edge with no accept.

Bus drive:
- o_memAddr = s1Valid ? s1Addr : 0.
- o_memDataOut = s1Valid ? s1Data : 0.
- o_memWrEn = s1Valid & s1Wr.

Read response:
- When s1Valid & ~s1Wr, the edge captures i_memDataIn into the owner's RdData register and sets the owner's RdValid for one cycle.
- RdData holds until that owner's next read.
- Writes produce no RdValid.

Starvation counter (starveCnt, 4 bits):
- Increments when i_dbgReq & ~o_dbgGnt, saturating at STARVE_LIMIT.
- Clears to 0 when o_dbgGnt or ~i_dbgReq.

Reset values:
- All outputs 0.
- starveCnt 0, s1Valid 0.
- Reset asserted mid-transfer immediately drops o_memWrEn and discards the pending read response; no RdValid follows.

## Timing
- Accept at edge N.
- Cycle N+1: bus is driven; a write commits at edge N+1.
- Read data is sampled at edge N+1; RdValid and RdData are visible in cycle N+2.
- Throughput is one transfer per cycle across both requesters.
- Back-to-back accepts, including by the same requester, keep the bus continuously driven.
- Simultaneous requests without forceDbg: the core is granted and the debug port waits.
- Simultaneous requests with forceDbg: the debug port is granted, and the counter clears at that edge.
- Read response of transfer K and bus drive of transfer K+1 occur in the same cycle; the two never conflict.

## Configuration
MEM_ARB_STARVE_GUARD_EN:
- Defined: starveCnt and forceDbg are implemented as above.
- Undefined: no counter, forceDbg is tied to 0, strict core priority, and STARVE_LIMIT is unused. The debug port can be starved indefinitely.

## Test plan
1. Core write, addr 0x0009, data 0xA5A5, req in cycle N.
   - o_coreGnt=1 in N.
   - o_memWrEn=1 only in N+1, with o_memAddr=0x0009 and o_memDataOut=0xA5A5.
   - No RdValid.
2. Debug read, addr 0x0014, i_memDataIn=0x1234 in N+1.
   - o_dbgRdValid=1 only in N+2, with o_dbgRdData=0x1234.
   - o_dbgRdData holds 0x1234 afterwards.
3. Both request in N, core drops req in N+1.
   - Core granted in N, debug granted in N+1.
   - Bus shows the core address in N+1 and the debug address in N+2.
4. Guard defined, STARVE_LIMIT=4, both request every cycle from N.
   - Core granted N..N+3, debug granted N+4, core granted again N+5.
   - Repeats with period 5.
5. Guard undefined, same stimulus as scenario 4.
   - o_dbgGnt stays 0 for 50 cycles.
   - Debug is granted in the first cycle the core drops req.
6. Core write accepted at N, i_rstn pulled low mid-cycle N+1.
   - o_memWrEn drops immediately and all outputs read 0.
   - After release, the first access is accepted normally with starveCnt=0.
